// File: rtl/decoder_seq.sv
// Registered N-way decoder with direct-decode and auto-scan modes (one-hot output, selectable polarity).
// Scan mode, dwell counter and wrap pulse are compiled in only when DECODER_SEQ_SCAN_EN is defined.
module decoder_seq #(
    parameter int SEL_W      = 3,
    parameter int DWELL_W    = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  start,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(2**SEL_W)-1:0] y,
    output logic [SEL_W-1:0]      idx,
    output logic                  valid,
    output logic                  wrap
);

    localparam int N = 2**SEL_W;
    localparam logic [N-1:0] Y_OFF = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t state;

    function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] s);
        logic [N-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return ACTIVE_LOW ? ~v : v;
    endfunction

`ifdef DECODER_SEQ_SCAN_EN
    logic [DWELL_W-1:0] dwell_cnt;

    // en dominates; then mode selects direct decode, else start (re)launches a scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            y         <= Y_OFF;
            idx       <= '0;
            valid     <= 1'b0;
            wrap      <= 1'b0;
            dwell_cnt <= '0;
        end else if (!en) begin
            state <= IDLE;
            y     <= Y_OFF;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else if (!mode) begin
            state <= DIRECT;
            y     <= decode(sel);
            idx   <= sel;
            valid <= 1'b1;
            wrap  <= 1'b0;
        end else if (start) begin
            state     <= SCAN;
            y         <= decode('0);
            idx       <= '0;
            valid     <= 1'b1;
            wrap      <= 1'b0;
            dwell_cnt <= dwell;
        end else if (state == SCAN) begin
            if (dwell_cnt == '0) begin
                // dwell is resampled only here, so mid-index changes wait for the next advance
                y         <= decode(idx + 1'b1);
                idx       <= idx + 1'b1;
                wrap      <= (idx == {SEL_W{1'b1}});
                dwell_cnt <= dwell;
            end else begin
                wrap      <= 1'b0;
                dwell_cnt <= dwell_cnt - 1'b1;
            end
            valid <= 1'b1;
        end else begin
            state <= IDLE;
            y     <= Y_OFF;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end
    end
`else
    logic unused_scan_inputs;
    assign unused_scan_inputs = ^{mode, start, dwell, state};

    // Without scan support, en alone chooses between IDLE and DIRECT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            y     <= Y_OFF;
            idx   <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else if (!en) begin
            state <= IDLE;
            y     <= Y_OFF;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= DIRECT;
            y     <= decode(sel);
            idx   <= sel;
            valid <= 1'b1;
            wrap  <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_seq.sv
// Directed self-checking bench for decoder_seq (SEL_W=3, ACTIVE_LOW=1).
// Scan scenarios run when DECODER_SEQ_SCAN_EN is defined, the scan-disabled scenario otherwise.
module tb_decoder_seq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] sel;
    logic       start;
    logic [3:0] dwell;
    logic [7:0] y;
    logic [2:0] idx;
    logic       valid;
    logic       wrap;

    int errors = 0;
    int checks = 0;

    decoder_seq #(.SEL_W(3), .DWELL_W(4), .ACTIVE_LOW(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .sel   (sel),
        .start (start),
        .dwell (dwell),
        .y     (y),
        .idx   (idx),
        .valid (valid),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock and land 1ns after the edge so outputs are settled
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; start = 1'b0; dwell = '0;
        #12;
        checks++; if (y !== 8'hFF) begin errors++; $display("[TB] FAIL reset_y got=%h exp=ff", y); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (idx !== 3'd0) begin errors++; $display("[TB] FAIL reset_idx got=%0d exp=0", idx); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap got=%b exp=0", wrap); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset got=%b exp=0", valid); end
    endtask

    task automatic test_direct();
        logic [2:0] sels [5] = '{3'd5, 3'd0, 3'd7, 3'd2, 3'd3};
        logic [7:0] exps [5] = '{8'b1101_1111, 8'b1111_1110, 8'b0111_1111, 8'b1111_1011, 8'b1111_0111};
        en = 1'b1; mode = 1'b0;
        // sel changes every cycle: each edge must show the decode of the previous sel with no gap
        for (int i = 0; i < 5; i++) begin
            sel = sels[i];
            step();
            checks++; if (y !== exps[i]) begin errors++; $display("[TB] FAIL direct_y sel=%0d got=%b exp=%b", sels[i], y, exps[i]); end
            checks++; if (idx !== sels[i]) begin errors++; $display("[TB] FAIL direct_idx got=%0d exp=%0d", idx, sels[i]); end
            checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL direct_valid got=%b exp=1", valid); end
        end
    endtask

    task automatic test_enable_off();
        en = 1'b1; mode = 1'b0; sel = 3'd6;
        step();
        en = 1'b0; sel = 3'd1;
        step();
        checks++; if (y !== 8'hFF) begin errors++; $display("[TB] FAIL en_off_y got=%h exp=ff", y); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL en_off_valid got=%b exp=0", valid); end
        checks++; if (idx !== 3'd6) begin errors++; $display("[TB] FAIL en_off_idx_hold got=%0d exp=6", idx); end
    endtask

    task automatic test_async_reset();
        en = 1'b1; mode = 1'b0; sel = 3'd4;
        step();
        checks++; if (y !== 8'b1110_1111) begin errors++; $display("[TB] FAIL pre_reset_y got=%b exp=11101111", y); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (y !== 8'hFF) begin errors++; $display("[TB] FAIL async_reset_y got=%h exp=ff", y); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_valid got=%b exp=0", valid); end
        checks++; if (idx !== 3'd0) begin errors++; $display("[TB] FAIL async_reset_idx got=%0d exp=0", idx); end
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle got=%b exp=0", valid); end
    endtask

`ifdef DECODER_SEQ_SCAN_EN
    task automatic test_scan_walk();
        logic [2:0] exp_idx;
        logic       exp_wrap;
        en = 1'b1; mode = 1'b1; dwell = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        // dwell=2 holds each index 3 cycles; the return to 0 lands on cycle 24
        for (int c = 0; c <= 24; c++) begin
            if (c > 0) step();
            exp_idx  = 3'((c / 3) % 8);
            exp_wrap = (c == 24);
            checks++; if (idx !== exp_idx) begin errors++; $display("[TB] FAIL scan_idx cyc=%0d got=%0d exp=%0d", c, idx, exp_idx); end
            checks++; if (wrap !== exp_wrap) begin errors++; $display("[TB] FAIL scan_wrap cyc=%0d got=%b exp=%b", c, wrap, exp_wrap); end
        end
        checks++; if (y !== 8'b1111_1110) begin errors++; $display("[TB] FAIL scan_wrap_y got=%b exp=11111110", y); end
    endtask

    task automatic test_dwell_resample();
        en = 1'b1; mode = 1'b1; dwell = 4'd1; start = 1'b1;
        step();
        start = 1'b0; dwell = 4'd0;
        step();
        checks++; if (idx !== 3'd0) begin errors++; $display("[TB] FAIL dwell_hold got=%0d exp=0", idx); end
        step();
        checks++; if (idx !== 3'd1) begin errors++; $display("[TB] FAIL dwell_adv got=%0d exp=1", idx); end
        step();
        checks++; if (idx !== 3'd2) begin errors++; $display("[TB] FAIL dwell_new got=%0d exp=2", idx); end
    endtask

    task automatic test_scan_abort();
        en = 1'b1; mode = 1'b1; dwell = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 4; c++) step();
        checks++; if (idx !== 3'd4) begin errors++; $display("[TB] FAIL abort_pre_idx got=%0d exp=4", idx); end
        en = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (y !== 8'hFF) begin errors++; $display("[TB] FAIL abort_y got=%h exp=ff", y); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid got=%b exp=0", valid); end
    endtask

    task automatic test_back_to_back();
        en = 1'b1; mode = 1'b1; dwell = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 6; c++) step();
        checks++; if (idx !== 3'd6) begin errors++; $display("[TB] FAIL restart_pre_idx got=%0d exp=6", idx); end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (idx !== 3'd0) begin errors++; $display("[TB] FAIL restart_idx got=%0d exp=0", idx); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL restart_wrap got=%b exp=0", wrap); end
        step();
        mode = 1'b0; sel = 3'd2;
        step();
        checks++; if (y !== 8'b1111_1011) begin errors++; $display("[TB] FAIL scan_to_direct_y got=%b exp=11111011", y); end
        checks++; if (idx !== 3'd2) begin errors++; $display("[TB] FAIL scan_to_direct_idx got=%0d exp=2", idx); end
        mode = 1'b1;
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_for_start got=%b exp=0", valid); end
    endtask
`else
    task automatic test_no_scan();
        en = 1'b1; mode = 1'b1; start = 1'b1; dwell = 4'd2; sel = 3'd3;
        step();
        start = 1'b0;
        checks++; if (y !== 8'b1111_0111) begin errors++; $display("[TB] FAIL noscan_y got=%b exp=11110111", y); end
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL noscan_valid got=%b exp=1", valid); end
        for (int c = 0; c < 10; c++) begin
            step();
            checks++; if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL noscan_wrap cyc=%0d got=%b exp=0", c, wrap); end
            checks++; if (idx !== 3'd3) begin errors++; $display("[TB] FAIL noscan_idx cyc=%0d got=%0d exp=3", c, idx); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_direct();
        test_enable_off();
        test_async_reset();
`ifdef DECODER_SEQ_SCAN_EN
        test_scan_walk();
        test_dwell_resample();
        test_scan_abort();
        test_back_to_back();
`else
        test_no_scan();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
